// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encodings
// and the default operand width.
package serial_add_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_add_cell.sv
// Single-bit add cell: sum plus propagate/generate terms so the controller
// can form the next carry as g | (p & cin).
module add_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic p,
    output logic g
);

    assign p   = a ^ b;
    assign g   = a & b;
    assign sum = p ^ cin;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one add cell, LSB first, WIDTH cycles per add.
// Result, carry-out and signed overflow are registered on entry to DONE and
// held until the next completion.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   opa_reg, opb_reg, res_reg, res_next;
    logic [WIDTH-1:0]   sum_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               carry_reg, carry_next;
    logic               cout_reg, ovf_reg;
    logic               cell_sum, cell_p, cell_g;
    logic               accept, last_bit;

    add_cell u_cell (
        .a   (opa_reg[0]),
        .b   (opb_reg[0]),
        .cin (carry_reg),
        .sum (cell_sum),
        .p   (cell_p),
        .g   (cell_g)
    );

    assign carry_next = cell_g | (cell_p & carry_reg);
    assign last_bit   = (cnt_reg == CNT_W'(WIDTH - 1));
    assign accept     = start && (state_reg != ST_RUN);

    // Result shifts right with the new sum bit entering at the MSB; a
    // one-bit result is simply the sum bit.
    generate
        if (WIDTH == 1) begin : g_res_one
            assign res_next = cell_sum;
        end else begin : g_res_wide
            assign res_next = {cell_sum, res_reg[WIDTH-1:1]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic and state-decoded status outputs.
    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) state_next = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_bit) state_next = ST_DONE;
            end
            ST_DONE: begin
                ready      = 1'b1;
                done       = 1'b1;
                state_next = start ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand shifters, carry flop, counter and output capture. Overflow is
    // the carry into the MSB (carry_reg on the last bit) XOR the carry out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_reg   <= '0;
            opb_reg   <= '0;
            res_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            opa_reg   <= a;
            opb_reg   <= b;
            carry_reg <= cin;
            cnt_reg   <= '0;
            res_reg   <= '0;
        end else if (state_reg == ST_RUN) begin
            opa_reg   <= opa_reg >> 1;
            opb_reg   <= opb_reg >> 1;
            carry_reg <= carry_next;
            res_reg   <= res_next;
            cnt_reg   <= cnt_reg + CNT_W'(1);
            if (last_bit) begin
                sum_reg  <= res_next;
                cout_reg <= carry_next;
                ovf_reg  <= carry_reg ^ carry_next;
            end
        end
    end

    assign sum      = sum_reg;
    assign cout     = cout_reg;
    assign overflow = ovf_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and swept checks of the serial adder at WIDTH=8, 13 and 1.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // WIDTH=8 instance
    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       ready8, busy8, done8, cout8, ovf8;
    logic [7:0] held_sum = '0;
    logic       held_cout = 1'b0, held_ovf = 1'b0;

    // WIDTH=13 instance
    logic        start13 = 1'b0, cin13 = 1'b0;
    logic [12:0] a13 = '0, b13 = '0, sum13;
    logic        ready13, busy13, done13, cout13, ovf13;

    // WIDTH=1 instance
    logic start1 = 1'b0, cin1 = 1'b0;
    logic a1 = 1'b0, b1 = 1'b0, sum1;
    logic ready1, busy1, done1, cout1, ovf1;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
        .overflow(ovf8)
    );

    serial_add_ctrl #(.WIDTH(13)) dut13 (
        .clk(clk), .rst_n(rst_n), .start(start13), .a(a13), .b(b13), .cin(cin13),
        .ready(ready13), .busy(busy13), .done(done13), .sum(sum13), .cout(cout13),
        .overflow(ovf13)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
        .overflow(ovf1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Start must already be asserted with operands before the accepting edge.
    // Walks every cycle up to done, optionally pulsing start at RUN cycle
    // glitch_k, and returns at the negedge inside the DONE cycle.
    task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        input int glitch_k);
        logic [8:0] t;
        logic       eo;
        t  = {1'b0, ia} + {1'b0, ib} + {8'd0, ic};
        eo = (ia[7] == ib[7]) && (t[7] != ia[7]);
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        cin8 = ~ic;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k == glitch_k) begin
                start8 = 1'b1;
                a8 = 8'h11;
                b8 = 8'h22;
            end else begin
                start8 = 1'b0;
            end
            if (k < 8) begin
                chk("done_early", done8, 1'b0);
                chk("busy_run", busy8, 1'b1);
                chk("sum_held", sum8, held_sum);
                chk("cout_held", cout8, held_cout);
            end else begin
                chk("done_pulse", done8, 1'b1);
                chk("ready_done", ready8, 1'b1);
                chk("sum8", sum8, t[7:0]);
                chk("cout8", cout8, t[8]);
                chk("ovf8", ovf8, eo);
                held_sum  = t[7:0];
                held_cout = t[8];
                held_ovf  = eo;
            end
        end
        $display("W8 a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d ovf=%0d", ia, ib, ic, sum8, cout8, ovf8);
    endtask

    task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic);
        @(negedge clk);
        a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
        chk("ready_idle", ready8, 1'b1);
        run8(ia, ib, ic, -1);
    endtask

    task automatic op13(input logic [12:0] ia, input logic [12:0] ib, input logic ic);
        logic [13:0] t;
        logic        eo;
        int          n;
        t  = {1'b0, ia} + {1'b0, ib} + {13'd0, ic};
        eo = (ia[12] == ib[12]) && (t[12] != ia[12]);
        @(negedge clk);
        a13 = ia; b13 = ib; cin13 = ic; start13 = 1'b1;
        @(posedge clk);
        #1;
        start13 = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (done13) break;
        end
        chk("lat13", 64'(n), 64'd14);
        chk("sum13", sum13, t[12:0]);
        chk("cout13", cout13, t[13]);
        chk("ovf13", ovf13, eo);
        $display("W13 a=%04h b=%04h cin=%0d -> sum=%04h cout=%0d ovf=%0d", ia, ib, ic, sum13, cout13, ovf13);
    endtask

    task automatic op1(input logic ia, input logic ib, input logic ic);
        logic [1:0] t;
        logic       eo;
        int         n;
        t  = {1'b0, ia} + {1'b0, ib} + {1'b0, ic};
        eo = (ia == ib) && (t[0] != ia);
        @(negedge clk);
        a1 = ia; b1 = ib; cin1 = ic; start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (done1) break;
        end
        chk("lat1", 64'(n), 64'd2);
        chk("sum1", sum1, t[0]);
        chk("cout1", cout1, t[1]);
        chk("ovf1", ovf1, eo);
        $display("W1 a=%0d b=%0d cin=%0d -> sum=%0d cout=%0d ovf=%0d", ia, ib, ic, sum1, cout1, ovf1);
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_sum", sum8, 8'h00);
        chk("rst_cout", cout8, 1'b0);
        chk("rst_ovf", ovf8, 1'b0);
        chk("rst_done", done8, 1'b0);
        chk("rst_busy", busy8, 1'b0);
        chk("rst_ready", ready8, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Test 1 then back-to-back start in its DONE cycle
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
        run8(8'h5A, 8'h3C, 1'b0, -1);
        a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
        chk("ready_b2b", ready8, 1'b1);
        run8(8'h01, 8'h02, 1'b0, -1);

        // Test 2
        op8(8'hFF, 8'h01, 1'b0);
        op8(8'h80, 8'h80, 1'b0);

        // Test 3: start pulsed during RUN cycle 3 is ignored
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1; start8 = 1'b1;
        run8(8'hFF, 8'h00, 1'b1, 3);
        @(negedge clk);
        chk("idle_after_done", ready8, 1'b1);
        chk("no_queued_op", busy8, 1'b0);

        // Leave all outputs non-zero before the reset test
        op8(8'hC0, 8'h80, 1'b0);

        // Test 5: asynchronous reset after 3 RUN cycles
        @(negedge clk);
        a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sum", sum8, 8'h00);
        chk("arst_cout", cout8, 1'b0);
        chk("arst_ovf", ovf8, 1'b0);
        chk("arst_busy", busy8, 1'b0);
        chk("arst_ready", ready8, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            chk("arst_no_done", done8, 1'b0);
        end
        held_sum = 8'h00; held_cout = 1'b0; held_ovf = 1'b0;
        op8(8'h12, 8'h34, 1'b1);

        // Random sweep at WIDTH=8
        for (int i = 0; i < 60; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom));

        // Random sweep at WIDTH=13, with edge operands first
        op13(13'h1FFF, 13'h0001, 1'b0);
        op13(13'h0FFF, 13'h0000, 1'b1);
        for (int i = 0; i < 150; i++)
            op13(13'($urandom), 13'($urandom), 1'($urandom));

        // WIDTH=1: directed vector then exhaustive
        op1(1'b1, 1'b1, 1'b1);
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vv;
            vv = 3'(v);
            op1(vv[2], vv[1], vv[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller. Stores two WIDTH-bit operands, drives one single-bit add cell per cycle (LSB first), and consumes the cell's sum, propagate (p) and generate (g) outputs.
- Holds the running carry in a flop and assembles the result in a shift register.
- Trades WIDTH cycles of latency for one add cell. Used where area matters more than throughput; sits next to the parallel ripple/CLA adders in the adder library.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..64
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; accepted only when ready=1
a  in  WIDTH  operand A, sampled on accepted start
b  in  WIDTH  operand B, sampled on accepted start
cin  in  1  carry-in, sampled on accepted start
ready  out  1  high when a start is accepted this cycle (IDLE or DONE)
busy  out  1  high while in RUN
done  out  1  one-cycle pulse; result valid
sum  out  WIDTH  result, held until next accepted start
cout  out  1  carry out of the MSB
overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async assert, sync-style release): state=IDLE, all registers cleared.
  - Output values in reset: sum=0, cout=0, overflow=0, done=0, busy=0, ready=1.
- Three states: IDLE, RUN, DONE. Encodings live in the shared include.
- IDLE:
  - ready=1.
  - On start: load opA/opB shift registers from a/b, carry flop=cin, bit counter=0, result register=0, then go to RUN.
- RUN, each cycle:
  - Add cell inputs: a=opA[0], b=opB[0], cin=carry.
  - Next carry = g | (p & carry), using the cell's p/g outputs.
  - The cell's sum bit shifts into the result MSB; the result shifts right one place.
  - opA and opB shift right one place.
  - Counter increments.
  - When counter==WIDTH-1: capture the current carry-in as the MSB carry-in (for overflow), then go to DONE.
- start during RUN is ignored: no effect, no queuing.
- DONE (exactly one cycle):
  - done=1.
  - sum=result register; cout=carry flop; overflow = MSB carry-in XOR cout.
  - ready=1. A start here is accepted and goes straight to RUN (back-to-back). Otherwise go to IDLE.
- Outputs sum/cout/overflow are registered. They update only on entry to DONE and are stable at all other times.
- Latency: start accepted at edge N → done high in the cycle after edge N+WIDTH. With WIDTH=8, start sampled at edge 0 gives done high between edges 8 and 9.
- Throughput: one result per WIDTH+1 cycles when back-to-back.
- Arithmetic: unsigned modular sum. {cout,sum} = a + b + cin exactly. overflow is meaningful for two's-complement operands.
- WIDTH=1: RUN lasts one cycle; the MSB carry-in equals cin.
- rst_n low mid-RUN: operation aborts immediately, all outputs return to reset values, no done pulse. After release the block is in IDLE.
- a/b/cin may change freely after the accepting edge; only the sampled values are used.

Decomposition:
- Shared include (adder_defs.vh): state encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) and the default width constant.
- One sub-module instance: the existing single-bit AddCell (sum/p/g). No new sub-modules.
- Counter, shift registers and FSM stay in serial_add_ctrl.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x3C, cin=0, start at edge 0 → done only between edges 8 and 9; sum=0x96, cout=0, overflow=1.
2. a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, overflow=0. Then a=0x80, b=0x80, cin=0 → sum=0x00, cout=1, overflow=1.
3. a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1. Pulse start=1 with different operands at RUN cycle 3 → ignored; result unchanged, done still at the original cycle.
4. Back-to-back: assert start with a=0x01, b=0x02 in the DONE cycle of test 1 → ready=1 that cycle; second done exactly 9 cycles later with sum=0x03; first result held until then.
5. Reset mid-op: drop rst_n after 3 RUN cycles → sum=0, cout=0, overflow=0, busy=0, ready=1 immediately and asynchronously; no done pulse. A new start after release gives a correct result.
6. WIDTH=1 build: a=1, b=1, cin=1 → done one cycle after the RUN cycle; sum=1, cout=1, overflow=0. Random 1000-vector sweep at WIDTH=8 and WIDTH=13 checked against a+b+cin.
